// File: rtl/recursive_mult_seq_pkg.sv
// Shared definitions for the sequential recursive multiplier.
// Contents: FSM state enum, nibble tile width, and the mapping from a
// linear tile index k to its operand nibble positions and result shift.
package recursive_mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int TILE_W = 4;

    typedef struct packed {
        int unsigned i;      // multiplicand nibble
        int unsigned j;      // multiplier nibble
        int unsigned shift;  // bit weight of this tile in the product
    } tile_coord_t;

    // Tiles walk the multiplicand nibbles fastest: k = j*t + i.
    function automatic tile_coord_t tile_coord(input int unsigned k, input int unsigned t);
        tile_coord_t c;
        c.i     = k % t;
        c.j     = k / t;
        c.shift = TILE_W * (c.i + c.j);
        return c;
    endfunction

endpackage

// File: rtl/exact_4x4.sv
// Exact 4x4 unsigned multiplier tile.
// Ports: i_a, i_b 4-bit operands; o_p 8-bit product.
module exact_4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    assign o_p = {4'b0, i_a} * {4'b0, i_b};
endmodule

// File: rtl/mult_tile4x4_sel.sv
// 4x4 tile with runtime choice between exact and approximate product.
// Ports: i_a, i_b 4-bit operands; i_approx 1 selects approximate;
// o_p 8-bit tile product.
module mult_tile4x4_sel (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_approx,
    output logic [7:0] o_p
);
    logic [7:0] w_exact;
    logic [7:0] w_approx;

    exact_4x4 u_exact (.i_a(i_a), .i_b(i_b), .o_p(w_exact));
    n1_4x4    u_n1    (.i_a(i_a), .i_b(i_b), .o_p(w_approx));

    assign o_p = i_approx ? w_approx : w_exact;
endmodule

// File: rtl/n1_4x4.sv
// Approximate 4x4 unsigned multiplier tile.
// Low columns collapse to an OR of their partial products; the upper
// columns use a reduced carry network built around pp22/pp33.
// Ports: i_a, i_b 4-bit operands; o_p 8-bit approximate product.
module n1_4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [3:0][3:0] w_pp;  // w_pp[x][y] = a[x] & b[y]

    always_comb begin
        w_pp = '0;
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                w_pp[x][y] = i_a[x] & i_b[y];
            end
        end
    end

    assign o_p[0] = w_pp[0][0];
    assign o_p[1] = w_pp[1][0] | w_pp[0][1];
    assign o_p[2] = w_pp[2][0] | w_pp[1][1] | w_pp[0][2];
    assign o_p[3] = w_pp[3][0] | w_pp[2][1] | w_pp[1][2] | w_pp[0][3];
    assign o_p[4] = w_pp[3][1] | w_pp[2][2] | w_pp[1][3];
    assign o_p[5] = w_pp[3][2] ^ w_pp[2][3] ^ (w_pp[2][2] & (w_pp[1][3] | w_pp[3][1]));
    assign o_p[6] = (w_pp[3][3] & ~w_pp[2][2])
                  | (~w_pp[3][3] & w_pp[2][2] & (w_pp[3][1] | w_pp[1][3]));
    assign o_p[7] = w_pp[2][2] & w_pp[3][3];
endmodule

// File: rtl/recursive_mult_seq.sv
// Multi-cycle W x W unsigned multiplier built from one reused 4x4 tile.
// One tile per CALC cycle, each exact or approximate per the mask bit
// captured at accept; shifted tile products accumulate modulo 2^(2W).
// Ports: clk, rst (sync, active-high); in_valid/in_ready, in_a, in_b,
// in_approx_mask operand handshake; out_valid/out_ready, out_y result.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// CALC    | accumulating tile k, one tile per cycle
// DONE    | result held on out_y until out_ready
module recursive_mult_seq
    import recursive_mult_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic [(W/4)*(W/4)-1:0] in_approx_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_y
);
    localparam int T  = W / TILE_W;
    localparam int NT = T * T;
    localparam int KW = $clog2(NT);

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [NT-1:0]    r_mask;
    logic [2*W-1:0]   r_acc;
    logic [KW-1:0]    r_k;
    logic             r_in_ready;
    logic             r_out_valid;

    tile_coord_t      w_coord;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [7:0]       w_p;
    logic [2*W-1:0]   w_term;

    always_comb begin
        w_coord = tile_coord(32'(r_k), T);
        w_a_nib = 4'(r_a >> (TILE_W * w_coord.i));
        w_b_nib = 4'(r_b >> (TILE_W * w_coord.j));
        w_term  = {{(2*W-8){1'b0}}, w_p} << w_coord.shift;
    end

    mult_tile4x4_sel u_tile (
        .i_a      (w_a_nib),
        .i_b      (w_b_nib),
        .i_approx (r_mask[r_k]),
        .o_p      (w_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_mask      <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_mask     <= in_approx_mask;
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc <= r_acc + w_term;
                    if (r_k == KW'(NT - 1)) begin
                        r_k         <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DONE: begin
                    // in_ready rises one cycle after the output handshake.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_y     = r_acc;

endmodule

// File: tb/tb_recursive_mult_seq.sv
module tb_recursive_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // W=8 instance
    logic        rst8, iv8, ir8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [3:0]  m8;
    logic [15:0] y8;

    // W=16 instance
    logic        rst16, iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, m16;
    logic [31:0] y16;

    recursive_mult_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_approx_mask(m8),
        .out_valid(ov8), .out_ready(or8), .out_y(y8)
    );

    recursive_mult_seq #(.W(16)) dut16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16),
        .in_a(a16), .in_b(b16), .in_approx_mask(m16),
        .out_valid(ov16), .out_ready(or16), .out_y(y16)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q8[$];
    logic [31:0] q16[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  m;
        logic [15:0] y;
    } vec8_t;

    vec8_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tile_ref(input logic [3:0] a, input logic [3:0] b, input logic ap);
        logic [7:0] y;
        logic p00, p10, p01, p20, p11, p02, p30, p21, p12, p03;
        logic p31, p22, p13, p32, p23, p33;
        if (!ap) return {4'b0, a} * {4'b0, b};
        p00 = a[0]&b[0]; p10 = a[1]&b[0]; p01 = a[0]&b[1];
        p20 = a[2]&b[0]; p11 = a[1]&b[1]; p02 = a[0]&b[2];
        p30 = a[3]&b[0]; p21 = a[2]&b[1]; p12 = a[1]&b[2]; p03 = a[0]&b[3];
        p31 = a[3]&b[1]; p22 = a[2]&b[2]; p13 = a[1]&b[3];
        p32 = a[3]&b[2]; p23 = a[2]&b[3]; p33 = a[3]&b[3];
        y[0] = p00;
        y[1] = p10 | p01;
        y[2] = p20 | p11 | p02;
        y[3] = p30 | p21 | p12 | p03;
        y[4] = p31 | p22 | p13;
        y[5] = p32 ^ p23 ^ (p22 & (p13 | p31));
        y[6] = (p33 & ~p22) | (~p33 & p22 & (p31 | p13));
        y[7] = p22 & p33;
        return y;
    endfunction

    // t nibbles per operand; result taken modulo 2^(8t) by the caller.
    function automatic logic [31:0] mul_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] m, input int t);
        logic [31:0] acc;
        logic [7:0]  p;
        acc = '0;
        for (int j = 0; j < t; j++) begin
            for (int i = 0; i < t; i++) begin
                p = tile_ref(a[4*i +: 4], b[4*j +: 4], m[j*t + i]);
                acc = acc + ({24'b0, p} << (4*(i+j)));
            end
        end
        return acc;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m,
                        input logic [15:0] exp, input string tag);
        int c;
        logic [15:0] e;
        c = 0;
        while (!ir8 && c < 50) begin @(posedge clk); #1; c++; end
        chk({tag, " in_ready idle"}, 32'(ir8), 32'd1);
        a8 = a; b8 = b; m8 = m; iv8 = 1'b1;
        q8.push_back(exp);
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 4'($urandom);
        c = 0;
        while (!ov8 && c < 60) begin @(posedge clk); #1; c++; end
        chk({tag, " latency"}, 32'(c), 32'd4);
        chk({tag, " in_ready done"}, 32'(ir8), 32'd0);
        if (q8.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = q8.pop_front();
            chk({tag, " out_y"}, 32'(y8), 32'(e));
        end
        @(posedge clk); #1;
        chk({tag, " out_valid after hs"}, 32'(ov8), 32'd0);
        chk({tag, " in_ready after hs"}, 32'(ir8), 32'd1);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] m,
                         input logic [31:0] exp, input string tag);
        int c;
        logic [31:0] e;
        c = 0;
        while (!ir16 && c < 50) begin @(posedge clk); #1; c++; end
        chk({tag, " in_ready idle"}, 32'(ir16), 32'd1);
        a16 = a; b16 = b; m16 = m; iv16 = 1'b1;
        q16.push_back(exp);
        @(posedge clk); #1;
        iv16 = 1'b0;
        c = 0;
        while (!ov16 && c < 80) begin @(posedge clk); #1; c++; end
        chk({tag, " latency"}, 32'(c), 32'd16);
        if (q16.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = q16.pop_front();
            chk({tag, " out_y"}, y16, e);
        end
        @(posedge clk); #1;
        chk({tag, " in_ready after hs"}, 32'(ir16), 32'd1);
    endtask

    initial begin
        logic [15:0] held;
        logic [15:0] e;
        int c;

        vecs[0] = '{8'hFF, 8'hFF, 4'h0, 16'hFE01};
        vecs[1] = '{8'h03, 8'h03, 4'h1, 16'h0007};
        vecs[2] = '{8'h03, 8'h03, 4'h0, 16'h0009};
        vecs[3] = '{8'hFF, 8'hFF, 4'h1, 16'hFDDF};
        vecs[4] = '{8'h05, 8'h07, 4'h0, 16'h0023};
        vecs[5] = '{8'h00, 8'hFF, 4'hF, 16'h0000};
        vecs[6] = '{8'hFF, 8'hFF, 4'hF, 16'hD79F};
        vecs[7] = '{8'hA5, 8'h3C, 4'h0, 16'h26AC};
        for (int v = 8; v < 14; v++) begin
            vecs[v].a = 8'($urandom);
            vecs[v].b = 8'($urandom);
            vecs[v].m = (v < 11) ? 4'h0 : 4'($urandom);
            vecs[v].y = (v < 11) ? 16'(vecs[v].a) * 16'(vecs[v].b)
                                 : 16'(mul_ref({8'b0, vecs[v].a}, {8'b0, vecs[v].b}, {12'b0, vecs[v].m}, 2));
        end

        rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; m8 = '0; or8 = 1'b1;
        rst16 = 1'b1; iv16 = 1'b0; a16 = '0; b16 = '0; m16 = '0; or16 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst8 = 1'b0; rst16 = 1'b0;
        chk("reset in_ready", 32'(ir8), 32'd1);
        chk("reset out_valid", 32'(ov8), 32'd0);
        chk("reset out_y", 32'(y8), 32'd0);
        chk("reset16 in_ready", 32'(ir16), 32'd1);
        chk("reset16 out_y", y16, 32'd0);

        for (int v = 0; v < 14; v++) begin
            run8(vecs[v].a, vecs[v].b, vecs[v].m, vecs[v].y, $sformatf("vec%0d", v));
        end

        // Backpressure in DONE with ignored in_valid pulses.
        or8 = 1'b0;
        a8 = 8'h12; b8 = 8'h34; m8 = 4'h0; iv8 = 1'b1;
        q8.push_back(16'h03A8);
        @(posedge clk); #1;
        iv8 = 1'b0;
        c = 0;
        while (!ov8 && c < 60) begin @(posedge clk); #1; c++; end
        chk("bp latency", 32'(c), 32'd4);
        held = y8;
        for (int n = 0; n < 5; n++) begin
            a8 = 8'hFF; b8 = 8'hFF; m8 = 4'hF; iv8 = n[0];
            @(posedge clk); #1;
            chk("bp out_y stable", 32'(y8), 32'(held));
            chk("bp out_valid held", 32'(ov8), 32'd1);
            chk("bp in_ready low", 32'(ir8), 32'd0);
        end
        iv8 = 1'b0;
        e = q8.pop_front();
        chk("bp out_y", 32'(y8), 32'(e));
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", 32'(ov8), 32'd0);
        chk("bp release in_ready", 32'(ir8), 32'd1);

        // Reset in the middle of CALC.
        a8 = 8'hFF; b8 = 8'hFF; m8 = 4'h0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        chk("midrst in_ready", 32'(ir8), 32'd1);
        chk("midrst out_valid", 32'(ov8), 32'd0);
        chk("midrst out_y", 32'(y8), 32'd0);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            chk("midrst no output", 32'(ov8), 32'd0);
        end
        run8(8'h05, 8'h07, 4'h0, 16'h0023, "after rst");

        run16(16'hFFFF, 16'hFFFF, 16'h0000, 32'hFFFE0001, "w16 max");
        a16 = 16'($urandom); b16 = 16'($urandom); m16 = 16'($urandom);
        run16(a16, b16, m16, mul_ref(a16, b16, m16, 4), "w16 rnd mask");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
